// File: rtl/udp_tx_frame.sv
// udp_tx_frame: builds one Ethernet/IPv4/UDP frame per accepted request.
// Emits preamble, headers, payload, zero pad and FCS as a byte stream.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   tx_start, tx_len   frame request pulse and UDP payload byte count
//   des_mac, des_ip    per-frame destination addresses
//   src_port, dst_port per-frame UDP ports
//   pay_req, pay_data  show-ahead payload source (byte valid with pay_req)
//   tx_data, tx_valid  frame byte stream, preamble through FCS
//   tx_busy            high from accepted start through end of IFG
//   tx_done            one-cycle pulse in the first IFG cycle
//   tx_len_err         one-cycle pulse when a request is too long
module udp_tx_frame #(
  parameter logic [47:0] fpga_mac   = 48'h11_22_33_44_55_66,
  parameter logic [31:0] fpga_ip    = 32'hc0_a8_00_08,
  parameter int          len_w      = 11,
  parameter int          ifg_cycles = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [len_w-1:0] tx_len,
  input  logic [47:0]      des_mac,
  input  logic [31:0]      des_ip,
  input  logic [15:0]      src_port,
  input  logic [15:0]      dst_port,
  output logic             pay_req,
  input  logic [7:0]       pay_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_len_err
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] PREAMBLE = 4'd1;
  localparam logic [3:0] ETH_HDR  = 4'd2;
  localparam logic [3:0] IP_HDR   = 4'd3;
  localparam logic [3:0] UDP_HDR  = 4'd4;
  localparam logic [3:0] PAYLOAD  = 4'd5;
  localparam logic [3:0] PAD      = 4'd6;
  localparam logic [3:0] FCS      = 4'd7;
  localparam logic [3:0] IFG      = 4'd8;

  localparam logic [15:0] IFG_LAST = 16'(ifg_cycles - 1);

  logic [3:0]   state;
  logic [15:0]  cnt;
  logic [15:0]  len_q;
  logic [47:0]  mac_q;
  logic [31:0]  ip_q;
  logic [15:0]  sport_q;
  logic [15:0]  dport_q;
  logic [15:0]  ip_id;
  logic [31:0]  crc;
  logic [31:0]  fcs;
  logic [15:0]  ip_len;
  logic [15:0]  udp_len;
  logic [15:0]  ip_chk;
  logic [31:0]  sum0;
  logic [16:0]  sum1;
  logic [335:0] hdr;
  logic [5:0]   hidx;
  logic [7:0]   hdr_byte;
  logic [7:0]   byte_out;
  logic         crc_en;

  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  assign ip_len  = len_q + 16'd28;
  assign udp_len = len_q + 16'd8;

  // Nine header words; at most a 4-bit carry, so two folds suffice.
  assign sum0 = 32'h4500 + 32'(ip_len) + 32'(ip_id)
              + 32'h4000 + 32'h4011
              + 32'(fpga_ip[31:16]) + 32'(fpga_ip[15:0])
              + 32'(ip_q[31:16]) + 32'(ip_q[15:0]);
  assign sum1   = 17'(sum0[15:0]) + 17'(sum0[31:16]);
  assign ip_chk = ~(sum1[15:0] + 16'(sum1[16]));

  // ETH, IP and UDP headers as one 42-byte image, indexed by cnt.
  assign hdr = {mac_q, fpga_mac, 16'h0800,
                16'h4500, ip_len, ip_id, 16'h4000, 16'h4011,
                ip_chk, fpga_ip, ip_q,
                sport_q, dport_q, udp_len, 16'h0000};
  assign hidx     = cnt[5:0];
  assign hdr_byte = hdr[{6'd41 - hidx, 3'b000} +: 8];
  assign fcs      = ~crc;

  always_comb begin
    byte_out = 8'h00;
    tx_valid = 1'b0;
    pay_req  = 1'b0;
    crc_en   = 1'b0;
    case (state)
      PREAMBLE: begin
        tx_valid = 1'b1;
        byte_out = (cnt == 16'd7) ? 8'hD5 : 8'h55;
      end
      ETH_HDR, IP_HDR, UDP_HDR: begin
        tx_valid = 1'b1;
        crc_en   = 1'b1;
        byte_out = hdr_byte;
      end
      PAYLOAD: begin
        tx_valid = 1'b1;
        crc_en   = 1'b1;
        pay_req  = 1'b1;
        byte_out = pay_data;
      end
      PAD: begin
        tx_valid = 1'b1;
        crc_en   = 1'b1;
      end
      FCS: begin
        tx_valid = 1'b1;
        byte_out = fcs[{cnt[1:0], 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  assign tx_data = byte_out;
  assign tx_busy = (state != IDLE);
  assign tx_done = (state == IFG) && (cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      len_q      <= 16'd0;
      mac_q      <= 48'd0;
      ip_q       <= 32'd0;
      sport_q    <= 16'd0;
      dport_q    <= 16'd0;
      ip_id      <= 16'd0;
      crc        <= 32'hFFFF_FFFF;
      tx_len_err <= 1'b0;
    end else begin
      tx_len_err <= 1'b0;
      cnt        <= cnt + 16'd1;
      if (crc_en)
        crc <= crc_step(crc, byte_out);
      case (state)
        IDLE: begin
          cnt <= 16'd0;
          if (tx_start) begin
            if (32'(tx_len) > 32'd1472) begin
              tx_len_err <= 1'b1;
            end else begin
              len_q   <= 16'(tx_len);
              mac_q   <= des_mac;
              ip_q    <= des_ip;
              sport_q <= src_port;
              dport_q <= dst_port;
              crc     <= 32'hFFFF_FFFF;
              state   <= PREAMBLE;
            end
          end
        end
        PREAMBLE: if (cnt == 16'd7) begin
          state <= ETH_HDR;
          cnt   <= 16'd0;
        end
        ETH_HDR: if (cnt == 16'd13) state <= IP_HDR;
        IP_HDR:  if (cnt == 16'd33) state <= UDP_HDR;
        UDP_HDR: if (cnt == 16'd41) begin
          cnt   <= 16'd0;
          state <= (len_q == 16'd0) ? PAD : PAYLOAD;
        end
        PAYLOAD: if (cnt == len_q - 16'd1) begin
          if (len_q >= 16'd18) begin
            state <= FCS;
            cnt   <= 16'd0;
          end else begin
            // pad runs cnt = len .. 17, i.e. 18 - len bytes
            state <= PAD;
            cnt   <= len_q;
          end
        end
        PAD: if (cnt == 16'd17) begin
          state <= FCS;
          cnt   <= 16'd0;
        end
        FCS: if (cnt == 16'd3) begin
          state <= IFG;
          cnt   <= 16'd0;
          ip_id <= ip_id + 16'd1;
        end
        IFG: if (cnt == IFG_LAST) begin
          state <= IDLE;
          cnt   <= 16'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_frame.sv
// tb_udp_tx_frame: scoreboard bench for udp_tx_frame.
// Stimulus queues expected bytes; a monitor pops and compares them.
module tb_udp_tx_frame;

  localparam logic [47:0] MAC_D   = 48'h0a_1b_2c_3d_4e_5f;
  localparam logic [47:0] SRC_MAC = 48'h11_22_33_44_55_66;
  localparam logic [31:0] SRC_IP  = 32'hc0_a8_00_08;
  localparam logic [31:0] IP_D    = 32'hc0_a8_00_02;
  localparam logic [15:0] SP      = 16'h1234;
  localparam logic [15:0] DP      = 16'h5678;

  typedef struct {
    int vlen;
    int npay;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_start = 1'b0;
  logic [10:0] tx_len = 11'd0;
  logic [47:0] des_mac = 48'd0;
  logic [31:0] des_ip = 32'd0;
  logic [15:0] src_port = 16'd0;
  logic [15:0] dst_port = 16'd0;
  logic        pay_req;
  logic [7:0]  pay_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_len_err;
  logic [7:0]  pay_base = 8'd0;
  logic [7:0]  pidx = 8'd0;

  logic [7:0]  exp_q[$];
  frame_t      frm_q[$];
  int          n_vec = 0;
  int          n_fail = 0;

  udp_tx_frame dut (
    .clk        (clk),
    .rst        (rst),
    .tx_start   (tx_start),
    .tx_len     (tx_len),
    .des_mac    (des_mac),
    .des_ip     (des_ip),
    .src_port   (src_port),
    .dst_port   (dst_port),
    .pay_req    (pay_req),
    .pay_data   (pay_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_len_err (tx_len_err)
  );

  always #5 clk = ~clk;

  assign pay_data = pay_base + pidx;

  always @(posedge clk) begin
    if (tx_start && !tx_busy) pidx <= 8'd0;
    else if (pay_req)         pidx <= pidx + 8'd1;
  end

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic queue_frame(
    input int          len,
    input logic [15:0] id,
    input logic [15:0] chk,
    input logic [7:0]  pb
  );
    logic [7:0]   b[$];
    logic [31:0]  c;
    logic [335:0] h;
    logic [15:0]  tl;
    logic [15:0]  ul;
    tl = 16'(len + 28);
    ul = 16'(len + 8);
    h = {MAC_D, SRC_MAC, 16'h0800,
         16'h4500, tl, id, 16'h4000, 16'h4011,
         chk, SRC_IP, IP_D, SP, DP, ul, 16'h0000};
    for (int i = 0; i < 42; i++) b.push_back(h[335 - 8*i -: 8]);
    for (int i = 0; i < len; i++) b.push_back(pb + 8'(i));
    for (int i = len; i < 18; i++) b.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (b[i]) c = crc_byte(c, b[i]);
    c = ~c;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (b[i]) exp_q.push_back(b[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    frm_q.push_back('{vlen: 12 + b.size(), npay: len});
  endtask

  task automatic start_frame(
    input int          len,
    input logic [15:0] id,
    input logic [15:0] chk,
    input logic [7:0]  pb
  );
    queue_frame(len, id, chk, pb);
    @(posedge clk); #1;
    pay_base = pb;
    tx_len   = 11'(len);
    des_mac  = MAC_D;
    des_ip   = IP_D;
    src_port = SP;
    dst_port = DP;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    tx_len   = 11'd1471;
    des_mac  = '1;
    des_ip   = '1;
    src_port = 16'h0;
    dst_port = 16'h0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (tx_busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (tx_busy) check("idle_timeout", 32'(tx_busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    frm_q.delete();
    @(negedge clk);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_pay_req", 32'(pay_req), 32'd0);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_len_err", 32'(tx_len_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: compares every valid byte, frame length, pay_req count,
  // FCS residue, tx_done position and IFG length.
  initial begin
    int          run;
    int          npay;
    int          gap;
    logic        in_gap;
    logic [31:0] rc;
    logic [7:0]  e;
    frame_t      f;
    run = 0; npay = 0; gap = 0; in_gap = 1'b0;
    rc = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0; npay = 0; in_gap = 1'b0;
      end else if (tx_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("byte%0d", run), 32'(tx_data), 32'(e));
        end
        if (run == 8) rc = 32'hFFFF_FFFF;
        if (run >= 8) rc = crc_byte(rc, tx_data);
        run++;
        if (pay_req) npay++;
      end else begin
        if (tx_data != 8'h00) check("idle_data", 32'(tx_data), 32'd0);
        if (run > 0) begin
          if (frm_q.size() == 0) begin
            check("extra_frame", 32'(run), 32'd0);
          end else begin
            f = frm_q.pop_front();
            check("valid_len", 32'(run), 32'(f.vlen));
            check("pay_req_cnt", 32'(npay), 32'(f.npay));
          end
          check("fcs_residue", rc, 32'hDEBB_20E3);
          check("tx_done", 32'(tx_done), 32'd1);
          run = 0; npay = 0; in_gap = 1'b1; gap = 0;
        end else if (tx_done) begin
          check("tx_done_stray", 32'(tx_done), 32'd0);
        end
        if (in_gap) begin
          if (tx_busy) gap++;
          else begin
            check("ifg_gap", 32'(gap), 32'd12);
            in_gap = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset();

    start_frame(10, 16'h0000, 16'hB96C, 8'hA0);
    wait_idle(300);
    start_frame(0, 16'h0001, 16'hB975, 8'h00);
    wait_idle(300);
    start_frame(18, 16'h0002, 16'hB962, 8'h40);
    wait_idle(300);
    start_frame(1472, 16'h0003, 16'hB3B3, 8'h05);
    wait_idle(2000);

    @(posedge clk); #1;
    tx_len = 11'd1473;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    @(negedge clk);
    check("len_err_pulse", 32'(tx_len_err), 32'd1);
    check("len_err_valid", 32'(tx_valid), 32'd0);
    check("len_err_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    check("len_err_clear", 32'(tx_len_err), 32'd0);
    repeat (4) @(negedge clk);
    check("len_err_novalid", 32'(tx_valid), 32'd0);

    do_reset();
    start_frame(5, 16'h0000, 16'hB971, 8'h30);
    repeat (20) @(posedge clk);
    #1;
    tx_len = 11'd1500;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    @(negedge clk);
    check("busy_start_no_err", 32'(tx_len_err), 32'd0);
    wait_idle(300);
    start_frame(20, 16'h0001, 16'hB961, 8'h70);
    wait_idle(300);

    start_frame(30, 16'h0002, 16'hB956, 8'h11);
    n = 0;
    while (!pay_req && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_payload", 32'(pay_req), 32'd1);
    repeat (3) @(posedge clk);
    do_reset();

    start_frame(12, 16'h0000, 16'hB96A, 8'hC0);
    wait_idle(300);

    repeat (4) @(posedge clk);
    check("exp_q_left", 32'(exp_q.size()), 32'd0);
    check("frm_q_left", 32'(frm_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
